// File: rtl/axi_read_responder_pkg.sv
// Shared types for the AXI read responder: response codes, FSM states, queued AR request.
// Request struct is sized by the package defaults for address and id width.
package axi_resp_pkg;

    localparam int AR_ADDR_W = 32;
    localparam int AR_ID_W   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [AR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [AR_ID_W-1:0]   id;
        logic                 err;
    } ar_req_t;

    // 17-bit span covers the largest burst (256 beats of 128 bytes) plus a 4 KB page offset.
    function automatic logic burst_err(input logic [11:0] addr_lo,
                                       input logic [7:0]  len,
                                       input logic [2:0]  size,
                                       input int          max_beats,
                                       input int          max_size);
        logic [16:0] beats;
        logic [16:0] span;
        logic [16:0] end_off;
        beats   = 17'(len) + 17'd1;
        span    = beats << size;
        end_off = 17'(addr_lo) + span;
        return (beats > 17'(max_beats)) || (32'(size) > max_size) || (end_off > 17'd4096);
    endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// AR and R channel bundle for the read responder.
// master drives requests and rready; slave drives arready and the R beat.
interface axi_read_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [ID_WIDTH-1:0]   arid;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   rid;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arid, rready,
        input  arready, rvalid, rdata, rid, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arid, rready,
        output arready, rvalid, rdata, rid, rresp, rlast
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; head is visible combinationally on pop_dat_o.
// Latency: an entry pushed at one edge is readable right after it.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read slave model: queues AR requests, returns arlen+1 R beats each, rdata = beat address.
// Latency: AR handshake at edge E0 -> first rvalid after E1; bursts chain with no bubble.
// Backpressure: R beat held while rready=0; arready low when the queue is full. AXI_RESP_THROTTLE_EN adds a 1-cycle gap between beats.
module axi_read_responder
    import axi_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4,
    parameter int MAX_BEATS  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    axi_read_responder_if.slave  bus,
    output logic                 busy
);
    localparam int SIZE_MAX = $clog2(DATA_WIDTH / 8);
    localparam int REQ_W    = $bits(ar_req_t);

    state_t                state_q, state_d;
    logic                  ready_en_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  err_q, err_d;

    logic                  full, empty, push, load, rvalid, last_beat;
    ar_req_t               req_in, head;
    logic [REQ_W-1:0]      head_raw;

    assign bus.arready = ready_en_q & ~full;
    assign push        = bus.arvalid & bus.arready;

    always_comb begin
        req_in.addr = AR_ADDR_W'(bus.araddr);
        req_in.len  = bus.arlen;
        req_in.size = bus.arsize;
        req_in.id   = AR_ID_W'(bus.arid);
        req_in.err  = burst_err(bus.araddr[11:0], bus.arlen, bus.arsize, MAX_BEATS, SIZE_MAX);
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_ar_q (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_dat_i (req_in),
        .pop_i      (load),
        .pop_dat_o  (head_raw),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign head      = ar_req_t'(head_raw);
    assign rvalid    = (state_q == ST_BURST);
    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        len_d   = len_q;
        size_d  = size_q;
        id_d    = id_q;
        err_d   = err_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) load = 1'b1;
            end
            ST_BURST: begin
                if (bus.rready) begin
                    if (last_beat) begin
                        if (!empty) load = 1'b1;
                        else        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
`ifdef AXI_RESP_THROTTLE_EN
                        state_d = ST_GAP;
`endif
                    end
                end
            end
`ifdef AXI_RESP_THROTTLE_EN
            ST_GAP: state_d = ST_BURST;
`endif
            default: state_d = ST_IDLE;
        endcase
        // Loading the next burst always lands in ST_BURST, so back-to-back bursts have no gap.
        if (load) begin
            state_d = ST_BURST;
            addr_d  = ADDR_WIDTH'(head.addr);
            beat_d  = 8'd0;
            len_d   = head.len;
            size_d  = head.size;
            id_d    = ID_WIDTH'(head.id);
            err_d   = head.err;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            addr_q     <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            size_q     <= size_d;
            id_q       <= id_d;
            err_q      <= err_d;
        end
    end

    assign bus.rvalid = rvalid;
    assign bus.rdata  = (rvalid && !err_q) ? DATA_WIDTH'(addr_q) : '0;
    assign bus.rid    = id_q;
    assign bus.rresp  = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.rlast  = rvalid && last_beat;
    assign busy       = !empty || (state_q != ST_IDLE);
endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: table of AR requests plus hand-written corner sequences.
// Expected R beats are generated from each request and compared in order as the DUT emits them.
module tb_axi_read_responder;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int MAXB  = 16;

    logic clock = 1'b0;
    logic reset_n;
    logic busy;

    always #5 clock = ~clock;

    axi_read_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();

    axi_read_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .DEPTH      (DEPTH),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic [1:0]  rresp;
        logic        rlast;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
        logic        err;
    } vec_t;

    beat_t sb[$];
    beat_t exp_b;
    beat_t held;
    logic  stall_prev = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    beats_exp = 0;
    int    beats_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic push_expected(input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [3:0] id, input logic err);
        beat_t       b;
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a       = addr + (32'(i) << size);
            b.rdata = err ? 32'h0 : a;
            b.rid   = id;
            b.rresp = err ? 2'b10 : 2'b00;
            b.rlast = (i == int'(len));
            sb.push_back(b);
            beats_exp++;
        end
    endtask

    // R monitor: scoreboard compare on each accepted beat, and hold check after each stalled cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_rvalid", bus.rvalid, 1);
                check("hold_rdata", bus.rdata, held.rdata);
                check("hold_rid", bus.rid, held.rid);
                check("hold_rlast", bus.rlast, held.rlast);
            end
            if (bus.rvalid && bus.rready) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    exp_b = sb.pop_front();
                    check("beat_rdata", bus.rdata, exp_b.rdata);
                    check("beat_rid", bus.rid, exp_b.rid);
                    check("beat_rresp", bus.rresp, exp_b.rresp);
                    check("beat_rlast", bus.rlast, exp_b.rlast);
                end
            end
            stall_prev  = bus.rvalid && !bus.rready;
            held.rdata  = bus.rdata;
            held.rid    = bus.rid;
            held.rlast  = bus.rlast;
        end
    end

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [3:0] id, input logic err);
        logic ok;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arid    = id;
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            ok = bus.arready;
        end
        if (!ok) fail_now("ar_handshake_timeout");
        else     push_expected(addr, len, size, id, err);
        @(posedge clock);
        #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_rvalid();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clock);
            seen = bus.rvalid;
        end
        if (!seen) fail_now("rvalid_timeout");
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clock);
            done = (sb.size() == 0);
        end
        if (!done) fail_now("drain_timeout");
        @(posedge clock);
        #1;
        check("drain_busy", busy, 0);
    endtask

    vec_t       vec[8];
    int         k;
    int         bubbles;
    logic [6:0] pat_exp;
    logic [7:0] rr_pat;

    initial begin
        vec[0] = '{32'h36f8fe20, 8'd255, 3'd2, 4'd5, 1'b1};
        vec[1] = '{32'h00000ff0, 8'd3,   3'd2, 4'd1, 1'b0};
        vec[2] = '{32'h00000ff4, 8'd3,   3'd2, 4'd2, 1'b1};
        vec[3] = '{32'h00000000, 8'd15,  3'd0, 4'd4, 1'b0};
        vec[4] = '{32'h00000000, 8'd16,  3'd0, 4'd6, 1'b1};
        vec[5] = '{32'h00000100, 8'd0,   3'd3, 4'd7, 1'b1};
        vec[6] = '{32'hfffffffc, 8'd0,   3'd2, 4'd8, 1'b0};
        vec[7] = '{32'h00000020, 8'd7,   3'd1, 4'd9, 1'b0};

        reset_n     = 1'b0;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = '0;
        bus.arid    = '0;
        bus.rready  = 1'b1;

        // Reset values and release behaviour
        repeat (2) @(posedge clock);
        #1;
        check("rst_arready", bus.arready, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rid", bus.rid, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rel_arready_before_edge", bus.arready, 0);
        @(posedge clock);
        #1;
        check("rel_arready_after_edge", bus.arready, 1);

        // Single read with first-beat latency
        send_ar(32'h1000, 8'd1, 3'd2, 4'd3, 1'b0);
        check("lat_e0_rvalid", bus.rvalid, 0);
        check("lat_e0_busy", busy, 1);
        @(posedge clock);
        #1;
        check("lat_e1_rvalid", bus.rvalid, 1);
        check("lat_e1_rdata", bus.rdata, 32'h1000);
        check("lat_e1_rlast", bus.rlast, 0);
        drain();

        for (int i = 0; i < 8; i++) begin
            send_ar(vec[i].addr, vec[i].len, vec[i].size, vec[i].id, vec[i].err);
            drain();
        end

        // Queue fill with rready low: one burst in the FSM plus DEPTH queued entries
        bus.rready = 1'b0;
        k = 0;
        bus.arlen   = 8'd1;
        bus.arsize  = 3'd2;
        bus.araddr  = 32'h200;
        bus.arid    = 4'd0;
        bus.arvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (!bus.arready) break;
            push_expected(bus.araddr, bus.arlen, bus.arsize, bus.arid, 1'b0);
            k++;
            @(posedge clock);
            #1;
            bus.araddr = 32'h200 + 32'(k) * 32'h100;
            bus.arid   = 4'(k);
        end
        bus.arvalid = 1'b0;
        check("fill_accepted", k, DEPTH + 1);
        check("fill_arready_low", bus.arready, 0);
        check("fill_busy", busy, 1);
        @(posedge clock);
        #1;
        bus.rready = 1'b1;
        bubbles = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
            if (!bus.rvalid) bubbles++;
        end
`ifdef AXI_RESP_THROTTLE_EN
        check("fill_bubbles", bubbles, 5);
`else
        check("fill_bubbles", bubbles, 0);
`endif
        drain();

        // Backpressure: rready 1,0,0,1 mid-burst, hold checked by the monitor
        bus.rready = 1'b0;
        send_ar(32'h2000, 8'd3, 3'd2, 4'd6, 1'b0);
        wait_rvalid();
        rr_pat = 8'b1001_1111;
        for (int c = 0; c < 8; c++) begin
            bus.rready = rr_pat[7-c];
            @(posedge clock);
            #1;
        end
        bus.rready = 1'b1;
        drain();

        // rvalid pattern for a 4-beat burst with rready held high
`ifdef AXI_RESP_THROTTLE_EN
        pat_exp = 7'b1010101;
`else
        pat_exp = 7'b1111000;
`endif
        send_ar(32'h3000, 8'd3, 3'd2, 4'd8, 1'b0);
        @(posedge clock);
        #1;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("pat_rvalid_%0d", c), bus.rvalid, pat_exp[6-c]);
            @(posedge clock);
            #1;
        end
        drain();

        // Reset during beat 1 with another request queued
        bus.rready = 1'b0;
        send_ar(32'h4000, 8'd3, 3'd2, 4'd7, 1'b0);
        wait_rvalid();
        bus.rready = 1'b1;
        @(posedge clock);
        #1;
        bus.rready = 1'b0;
        wait_rvalid();
        check("mid_rdata_beat1", bus.rdata, 32'h4004);
        send_ar(32'h5000, 8'd0, 3'd2, 4'd9, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_rlast", bus.rlast, 0);
        check("mid_rst_rdata", bus.rdata, 0);
        check("mid_rst_rid", bus.rid, 0);
        check("mid_rst_arready", bus.arready, 0);
        check("mid_rst_busy", busy, 0);
        beats_exp = beats_exp - sb.size();
        sb.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("mid_rel_arready_before_edge", bus.arready, 0);
        @(posedge clock);
        #1;
        check("mid_rel_arready_after_edge", bus.arready, 1);
        check("mid_rel_busy", busy, 0);
        bus.rready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("mid_queue_empty_rvalid", bus.rvalid, 0);
        check("mid_queue_empty_busy", busy, 0);

        check("final_sb_empty", sb.size(), 0);
        check("beats_total", beats_seen, beats_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
